// File: rtl/ofs_plat_prim_rob_nchan_if.sv
// ofs_plat_prim_rob_nchan_if
// Bundle of the allocate / enqueue / dequeue signals of the multi-channel
// reorder buffer. Per-channel fields are packed with channel 0 in the
// least significant slice.
//   master : the bridge that allocates tags, returns responses and pops data
//   slave  : the reorder buffer itself
// Signals:
//   alloc_en, allocCnt, allocMeta   per-channel allocation request
//   notFull, allocIdx               per-channel allocation status
//   enq_en, enq_chan, enq_idx,
//   enq_data                        shared response enqueue bus
//   deq_en, notEmpty                per-channel in-order pop
//   T2_valid, T2_first,
//   T2_firstMeta                    popped data/meta, two cycles after deq_en
//   err                             sticky protocol error
interface ofs_plat_prim_rob_nchan_if #(
    parameter int N_CHANNELS          = 2,
    parameter int N_ENTRIES           = 256,
    parameter int N_DATA_BITS         = 512,
    parameter int N_META_BITS         = 8,
    parameter int MAX_ALLOC_PER_CYCLE = 4
);
    localparam int IDX_W  = $clog2(N_ENTRIES);
    localparam int CNT_W  = $clog2(MAX_ALLOC_PER_CYCLE) + 1;
    localparam int CHAN_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    logic [N_CHANNELS-1:0]             alloc_en;
    logic [N_CHANNELS*CNT_W-1:0]       allocCnt;
    logic [N_CHANNELS*N_META_BITS-1:0] allocMeta;
    logic [N_CHANNELS-1:0]             notFull;
    logic [N_CHANNELS*IDX_W-1:0]       allocIdx;

    logic                              enq_en;
    logic [CHAN_W-1:0]                 enq_chan;
    logic [IDX_W-1:0]                  enq_idx;
    logic [N_DATA_BITS-1:0]            enq_data;

    logic [N_CHANNELS-1:0]             deq_en;
    logic [N_CHANNELS-1:0]             notEmpty;
    logic [N_CHANNELS-1:0]             T2_valid;
    logic [N_CHANNELS*N_DATA_BITS-1:0] T2_first;
    logic [N_CHANNELS*N_META_BITS-1:0] T2_firstMeta;

    logic                              err;

    modport master (
        output alloc_en, allocCnt, allocMeta,
        output enq_en, enq_chan, enq_idx, enq_data,
        output deq_en,
        input  notFull, allocIdx, notEmpty,
        input  T2_valid, T2_first, T2_firstMeta, err
    );

    modport slave (
        input  alloc_en, allocCnt, allocMeta,
        input  enq_en, enq_chan, enq_idx, enq_data,
        input  deq_en,
        output notFull, allocIdx, notEmpty,
        output T2_valid, T2_first, T2_firstMeta, err
    );
endinterface

// File: rtl/ofs_plat_prim_rob_nchan.sv
// ofs_plat_prim_rob_nchan
// Multi-channel reorder buffer. Each channel owns an independent ring of
// N_ENTRIES slots: slots are allocated in order (up to MAX_ALLOC_PER_CYCLE
// per cycle), filled out of order from the shared enqueue bus addressed by
// (enq_chan, enq_idx), and popped in order. Popped data appears on T2_first
// two cycles after deq_en, together with the metadata of the allocation group
// the slot belonged to.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   rob    ofs_plat_prim_rob_nchan_if.slave (alloc / enq / deq / T2 / err)
// Build option:
//   OFS_PLAT_ROB_NCHAN_ERR_CHECK_EN  enables the sticky protocol checker on
//   rob.err; when undefined err is tied low and no checker logic exists.
module ofs_plat_prim_rob_nchan #(
    parameter int N_CHANNELS          = 2,
    parameter int N_ENTRIES           = 256,
    parameter int N_DATA_BITS         = 512,
    parameter int N_META_BITS         = 8,
    parameter int MAX_ALLOC_PER_CYCLE = 4
) (
    input  logic clk,
    input  logic reset,
    ofs_plat_prim_rob_nchan_if.slave rob
);
    localparam int IDX_W  = $clog2(N_ENTRIES);
    localparam int CNT_W  = $clog2(MAX_ALLOC_PER_CYCLE) + 1;
    localparam int CHAN_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    // notFull holds while used <= N_ENTRIES - MAX_ALLOC_PER_CYCLE
    localparam logic [IDX_W:0] FULL_THRESH = (IDX_W+1)'(N_ENTRIES - MAX_ALLOC_PER_CYCLE);
`ifdef OFS_PLAT_ROB_NCHAN_ERR_CHECK_EN
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ALLOC_PER_CYCLE);

    logic [N_CHANNELS-1:0] chan_err;
`endif

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan
        logic [IDX_W-1:0]       head_q, head_nxt;
        logic [IDX_W-1:0]       oldest_q, oldest_nxt;
        logic [IDX_W:0]         used_q, used_nxt;
        logic [N_ENTRIES-1:0]   valid_q, valid_nxt;
        logic                   not_full_q, not_empty_q;

        logic [CNT_W-1:0]       cnt;
        logic                   alloc_ok, deq, enq_hit;

        logic [N_DATA_BITS-1:0] data_ram [N_ENTRIES];
        logic [N_META_BITS-1:0] meta_ram [N_ENTRIES];
        logic [N_ENTRIES-1:0]   start_q;

        logic [N_DATA_BITS-1:0] rd_data;
        logic [N_META_BITS-1:0] rd_meta;
        logic                   rd_start;
        logic                   rd_valid;

        logic                   t2_valid_q;
        logic [N_DATA_BITS-1:0] t2_data_q;
        logic [N_META_BITS-1:0] t2_meta_q;

        assign cnt      = rob.allocCnt[c*CNT_W +: CNT_W];
        assign alloc_ok = rob.alloc_en[c] && not_full_q;
        assign deq      = rob.deq_en[c];
        assign enq_hit  = rob.enq_en && (rob.enq_chan == CHAN_W'(c));

        // Next-state view of the channel; notFull / notEmpty are registered
        // from it so they reflect this cycle's alloc, enq and deq.
        always_comb begin
            head_nxt   = head_q;
            oldest_nxt = oldest_q;
            used_nxt   = used_q;
            valid_nxt  = valid_q;
            if (alloc_ok) begin
                head_nxt = head_q + IDX_W'(cnt);
                used_nxt = used_nxt + (IDX_W+1)'(cnt);
            end
            if (deq) begin
                valid_nxt[oldest_q] = 1'b0;
                oldest_nxt          = oldest_q + IDX_W'(1);
                used_nxt            = used_nxt - (IDX_W+1)'(1);
            end
            if (enq_hit) begin
                valid_nxt[rob.enq_idx] = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                head_q      <= '0;
                oldest_q    <= '0;
                used_q      <= '0;
                valid_q     <= '0;
                not_full_q  <= 1'b1;
                not_empty_q <= 1'b0;
                rd_valid    <= 1'b0;
                t2_valid_q  <= 1'b0;
                t2_data_q   <= '0;
                t2_meta_q   <= '0;
            end else begin
                head_q      <= head_nxt;
                oldest_q    <= oldest_nxt;
                used_q      <= used_nxt;
                valid_q     <= valid_nxt;
                not_full_q  <= (used_nxt <= FULL_THRESH);
                not_empty_q <= valid_nxt[oldest_nxt];
                rd_valid    <= deq;
                t2_valid_q  <= rd_valid;
                if (rd_valid) begin
                    t2_data_q <= rd_data;
                    // Meta is stored once per group; non-start slots keep
                    // the value latched when the group's first slot popped.
                    if (rd_start) begin
                        t2_meta_q <= rd_meta;
                    end
                end
            end
        end

        // Storage arrays carry no reset so they can map onto RAM.
        always_ff @(posedge clk) begin
            if (enq_hit) begin
                data_ram[rob.enq_idx] <= rob.enq_data;
            end
            if (alloc_ok) begin
                meta_ram[head_q] <= rob.allocMeta[c*N_META_BITS +: N_META_BITS];
                for (int k = 0; k < MAX_ALLOC_PER_CYCLE; k++) begin
                    if (CNT_W'(k) < cnt) begin
                        start_q[head_q + IDX_W'(k)] <= (k == 0);
                    end
                end
            end
            if (deq) begin
                rd_data  <= data_ram[oldest_q];
                rd_meta  <= meta_ram[oldest_q];
                rd_start <= start_q[oldest_q];
            end
        end

        assign rob.notFull[c]                               = not_full_q;
        assign rob.allocIdx[c*IDX_W +: IDX_W]               = head_q;
        assign rob.notEmpty[c]                              = not_empty_q;
        assign rob.T2_valid[c]                              = t2_valid_q;
        assign rob.T2_first[c*N_DATA_BITS +: N_DATA_BITS]   = t2_data_q;
        assign rob.T2_firstMeta[c*N_META_BITS +: N_META_BITS] = t2_meta_q;

`ifdef OFS_PLAT_ROB_NCHAN_ERR_CHECK_EN
        // Offset of the target slot from oldest; it is allocated only when
        // the offset lies below the current used count.
        logic [IDX_W-1:0] enq_off;
        assign enq_off = rob.enq_idx - oldest_q;

        assign chan_err[c] = (enq_hit && valid_q[rob.enq_idx])
                          || (enq_hit && ({1'b0, enq_off} >= used_q))
                          || (deq && !not_empty_q)
                          || (rob.alloc_en[c] && (!not_full_q || (cnt == '0) || (cnt > MAX_CNT)));
`endif
    end

`ifdef OFS_PLAT_ROB_NCHAN_ERR_CHECK_EN
    logic chan_range_err;
    logic err_q;

    assign chan_range_err = rob.enq_en && (32'(rob.enq_chan) >= N_CHANNELS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (|chan_err) | chan_range_err;
        end
    end

    assign rob.err = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && ((|chan_err) || chan_range_err)) begin
            $error("ofs_plat_prim_rob_nchan: protocol error chan_err=%b chan_range=%b",
                   chan_err, chan_range_err);
        end
    end
`endif
`else
    assign rob.err = 1'b0;
`endif

endmodule
